// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init sequencer states and the
// mode-register word builder used by the init and future access controllers.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  typedef logic [3:0] sdram_cmd_t;

  localparam sdram_cmd_t CMD_NOP       = 4'b0111;
  localparam sdram_cmd_t CMD_ACTIVE    = 4'b0011;
  localparam sdram_cmd_t CMD_READ      = 4'b0101;
  localparam sdram_cmd_t CMD_WRITE     = 4'b0100;
  localparam sdram_cmd_t CMD_PRECHARGE = 4'b0010;
  localparam sdram_cmd_t CMD_AREF      = 4'b0001;
  localparam sdram_cmd_t CMD_LMR       = 4'b0000;

  typedef enum logic [2:0] {
    ST_WAIT_PWR,
    ST_PRECHARGE,
    ST_WAIT_TRP,
    ST_AREF,
    ST_WAIT_TRFC,
    ST_MRS,
    ST_WAIT_TMRD,
    ST_DONE
  } init_state_e;

  localparam int MODE_W = 10;

  function automatic logic [MODE_W-1:0] mode_word(
    input logic [2:0] cas_lat,
    input logic [2:0] burst_len,
    input logic       burst_type,
    input logic       wr_burst
  );
    return {wr_burst, 2'b00, cas_lat, burst_type, burst_len};
  endfunction

endpackage

// File: rtl/sdram_wait_counter.sv
// Loadable down-counter; o_done is high during the final cycle of a loaded wait,
// so a controller can change state on the same edge the wait expires.
module sdram_wait_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up initialisation sequencer: power wait, PRECHARGE ALL,
// AREF_NUM x AUTO REFRESH, LOAD MODE, then holds init_end_flag in DONE.
module sdram_init_ctrl
  import sdram_pkg::*;
#(
  parameter int         ADDR_W     = 13,
  parameter int         BA_W       = 2,
  parameter int         T_PWR_CYC  = 20000,
  parameter int         T_RP_CYC   = 2,
  parameter int         T_RFC_CYC  = 7,
  parameter int         T_MRD_CYC  = 2,
  parameter int         AREF_NUM   = 8,
  parameter int         CAS_LAT    = 3,
  parameter logic [2:0] BURST_LEN  = 3'b111,
  parameter logic       BURST_TYPE = 1'b0,
  parameter logic       WR_BURST   = 1'b0
) (
  input  logic              sysclk_100M,
  input  logic              rst_n,
  input  logic              reinit_req,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              init_end_flag
);

  localparam int CNT_W = $clog2(T_PWR_CYC + 1);
  localparam int ARF_W = $clog2(AREF_NUM + 1);

  init_state_e       r_state;
  init_state_e       w_next_state;
  logic              r_cke;
  sdram_cmd_t        r_cmd;
  logic [BA_W-1:0]   r_ba;
  logic [ADDR_W-1:0] r_addr;
  logic              r_init_end;
  logic [ARF_W-1:0]  r_aref_cnt;

  logic              w_wait_done;
  logic              w_cnt_load;
  logic [CNT_W-1:0]  w_cnt_val;
  logic              w_aref_more;
  sdram_cmd_t        w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic [MODE_W-1:0] w_mode;

  assign w_mode      = mode_word(3'(CAS_LAT), BURST_LEN, BURST_TYPE, WR_BURST);
  assign w_aref_more = (r_aref_cnt < ARF_W'(AREF_NUM));

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_WAIT_PWR:  if (w_wait_done) w_next_state = ST_PRECHARGE;
      ST_PRECHARGE: w_next_state = (T_RP_CYC > 1) ? ST_WAIT_TRP : ST_AREF;
      ST_WAIT_TRP:  if (w_wait_done) w_next_state = ST_AREF;
      ST_AREF: begin
        if (T_RFC_CYC > 1) w_next_state = ST_WAIT_TRFC;
        else               w_next_state = w_aref_more ? ST_AREF : ST_MRS;
      end
      ST_WAIT_TRFC: if (w_wait_done) w_next_state = w_aref_more ? ST_AREF : ST_MRS;
      ST_MRS:       w_next_state = (T_MRD_CYC > 1) ? ST_WAIT_TMRD : ST_DONE;
      ST_WAIT_TMRD: if (w_wait_done) w_next_state = ST_DONE;
      ST_DONE:      if (reinit_req) w_next_state = ST_PRECHARGE;
      default:      w_next_state = ST_WAIT_PWR;
    endcase
  end

  // The first clock after reset (cke still low) arms the power-up wait; after
  // that the counter is reloaded with the new state's length on every change.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    if (!r_cke) begin
      w_cnt_load = 1'b1;
      w_cnt_val  = CNT_W'(T_PWR_CYC);
    end else if (w_next_state != r_state) begin
      w_cnt_load = 1'b1;
      case (w_next_state)
        ST_WAIT_PWR:  w_cnt_val = CNT_W'(T_PWR_CYC);
        ST_WAIT_TRP:  w_cnt_val = CNT_W'(T_RP_CYC - 1);
        ST_WAIT_TRFC: w_cnt_val = CNT_W'(T_RFC_CYC - 1);
        ST_WAIT_TMRD: w_cnt_val = CNT_W'(T_MRD_CYC - 1);
        default:      w_cnt_val = '0;
      endcase
    end
  end

  sdram_wait_counter #(
    .W (CNT_W)
  ) u_wait_cnt (
    .clk        (sysclk_100M),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_done     (w_wait_done)
  );

  // Outputs are decoded from the next state so the registered bus matches r_state.
  always_comb begin
    w_cmd  = CMD_NOP;
    w_addr = '0;
    case (w_next_state)
      ST_PRECHARGE: begin
        w_cmd      = CMD_PRECHARGE;
        w_addr[10] = 1'b1;
      end
      ST_AREF: w_cmd = CMD_AREF;
      ST_MRS: begin
        w_cmd  = CMD_LMR;
        w_addr = ADDR_W'(w_mode);
      end
      default: begin
        w_cmd  = CMD_NOP;
        w_addr = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_WAIT_PWR;
      r_cke      <= 1'b0;
      r_cmd      <= CMD_NOP;
      r_ba       <= '0;
      r_addr     <= '0;
      r_init_end <= 1'b0;
      r_aref_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_cke      <= 1'b1;
      r_cmd      <= w_cmd;
      r_ba       <= '0;
      r_addr     <= w_addr;
      r_init_end <= (w_next_state == ST_DONE);
      if (w_next_state == ST_PRECHARGE) begin
        r_aref_cnt <= '0;
      end else if (w_next_state == ST_AREF && w_aref_more) begin
        r_aref_cnt <= r_aref_cnt + 1'b1;
      end
    end
  end

  assign sdram_cke     = r_cke;
  assign sdram_cs_n    = r_cmd[3];
  assign sdram_ras_n   = r_cmd[2];
  assign sdram_cas_n   = r_cmd[1];
  assign sdram_we_n    = r_cmd[0];
  assign sdram_ba      = r_ba;
  assign sdram_addr    = r_addr;
  assign init_end_flag = r_init_end;

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Self-checking bench for sdram_init_ctrl: default and reduced-timing instances,
// table-driven key cycles, a per-cycle schedule model, reinit and reset sequences.
`timescale 1ns/1ps
module tb_sdram_init_ctrl;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] LMR  = 4'b0000;
  localparam logic [20:0] RST_VEC = {1'b0, NOP, 2'b00, 13'h0000, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic reinit_req = 1'b0;
  logic v_reinit = 1'b0;
  logic mon_en = 1'b0;
  int   cyc = -1;
  int   model_pre = 20000;
  int   n_checks = 0;
  int   n_err = 0;

  logic d_cke, d_cs, d_ras, d_cas, d_we, d_flag;
  logic [1:0]  d_ba;
  logic [12:0] d_addr;
  logic v_cke, v_cs, v_ras, v_cas, v_we, v_flag;
  logic [1:0]  v_ba;
  logic [12:0] v_addr;
  logic [20:0] d_vec, v_vec;

  assign d_vec = {d_cke, d_cs, d_ras, d_cas, d_we, d_ba, d_addr, d_flag};
  assign v_vec = {v_cke, v_cs, v_ras, v_cas, v_we, v_ba, v_addr, v_flag};

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= -1;
    else        cyc <= cyc + 1;
  end

  sdram_init_ctrl u_dut (
    .sysclk_100M   (clk),
    .rst_n         (rst_n),
    .reinit_req    (reinit_req),
    .sdram_cke     (d_cke),
    .sdram_cs_n    (d_cs),
    .sdram_ras_n   (d_ras),
    .sdram_cas_n   (d_cas),
    .sdram_we_n    (d_we),
    .sdram_ba      (d_ba),
    .sdram_addr    (d_addr),
    .init_end_flag (d_flag)
  );

  sdram_init_ctrl #(
    .T_PWR_CYC (100),
    .AREF_NUM  (2),
    .T_RFC_CYC (1),
    .CAS_LAT   (2)
  ) u_var (
    .sysclk_100M   (clk),
    .rst_n         (rst_n),
    .reinit_req    (v_reinit),
    .sdram_cke     (v_cke),
    .sdram_cs_n    (v_cs),
    .sdram_ras_n   (v_ras),
    .sdram_cas_n   (v_cas),
    .sdram_we_n    (v_we),
    .sdram_ba      (v_ba),
    .sdram_addr    (v_addr),
    .init_end_flag (v_flag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Schedule model: commands placed by timing arithmetic from the PRECHARGE cycle.
  function automatic logic [20:0] exp_vec(input int c, input int pre, input int t_rp,
                                          input int t_rfc, input int n, input int t_mrd,
                                          input logic [12:0] mode, input logic in_rst);
    logic [3:0]  cmd;
    logic [12:0] addr;
    int d, lmr;
    if (in_rst || c < 0) return RST_VEC;
    cmd  = NOP;
    addr = 13'h0000;
    d    = c - pre;
    lmr  = t_rp + n * t_rfc;
    if (d == 0) begin
      cmd  = PRE;
      addr = 13'h0400;
    end else if (d >= t_rp && d < lmr && ((d - t_rp) % t_rfc) == 0) begin
      cmd = AREF;
    end else if (d == lmr) begin
      cmd  = LMR;
      addr = mode;
    end
    return {1'b1, cmd, 2'b00, addr, (d >= lmr + t_mrd)};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("d_no_x", 32'($isunknown(d_vec)), 32'd0);
      check("v_no_x", 32'($isunknown(v_vec)), 32'd0);
      check("d_sched", 32'(d_vec), 32'(exp_vec(cyc, model_pre, 2, 7, 8, 2, 13'h037, !rst_n)));
      check("v_sched", 32'(v_vec), 32'(exp_vec(cyc, 100, 2, 1, 2, 2, 13'h027, !rst_n)));
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          cyc;
    bit          var_dut;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        flag;
    bit          pulse;
    string       name;
  } vec_t;

  vec_t tbl[$];
  logic [20:0] act;
  int n;

  initial begin
    tbl.push_back('{0,     1'b0, NOP,  13'h000, 1'b0, 1'b0, "d_c0_nop"});
    tbl.push_back('{100,   1'b1, PRE,  13'h400, 1'b0, 1'b0, "v_pre"});
    tbl.push_back('{101,   1'b1, NOP,  13'h000, 1'b0, 1'b0, "v_trp"});
    tbl.push_back('{102,   1'b1, AREF, 13'h000, 1'b0, 1'b0, "v_aref0"});
    tbl.push_back('{103,   1'b1, AREF, 13'h000, 1'b0, 1'b0, "v_aref1"});
    tbl.push_back('{104,   1'b1, LMR,  13'h027, 1'b0, 1'b0, "v_mrs"});
    tbl.push_back('{105,   1'b1, NOP,  13'h000, 1'b0, 1'b0, "v_tmrd"});
    tbl.push_back('{106,   1'b1, NOP,  13'h000, 1'b1, 1'b0, "v_done"});
    tbl.push_back('{19999, 1'b0, NOP,  13'h000, 1'b0, 1'b0, "d_pwr_last"});
    tbl.push_back('{20000, 1'b0, PRE,  13'h400, 1'b0, 1'b0, "d_pre"});
    tbl.push_back('{20001, 1'b0, NOP,  13'h000, 1'b0, 1'b0, "d_trp"});
    tbl.push_back('{20002, 1'b0, AREF, 13'h000, 1'b0, 1'b0, "d_aref0"});
    tbl.push_back('{20004, 1'b0, NOP,  13'h000, 1'b0, 1'b1, "d_trfc_reinit"});
    tbl.push_back('{20009, 1'b0, AREF, 13'h000, 1'b0, 1'b0, "d_aref1"});
    tbl.push_back('{20051, 1'b0, AREF, 13'h000, 1'b0, 1'b0, "d_aref7"});
    tbl.push_back('{20052, 1'b0, NOP,  13'h000, 1'b0, 1'b0, "d_trfc7"});
    tbl.push_back('{20058, 1'b0, LMR,  13'h037, 1'b0, 1'b0, "d_mrs"});
    tbl.push_back('{20059, 1'b0, NOP,  13'h000, 1'b0, 1'b0, "d_tmrd"});
    tbl.push_back('{20060, 1'b0, NOP,  13'h000, 1'b1, 1'b0, "d_done"});

    #2 rst_n = 1'b0;
    #1 mon_en = 1'b1;
    #47;
    check("rst_vals_d", 32'(d_vec), 32'(RST_VEC));
    check("rst_vals_v", 32'(v_vec), 32'(RST_VEC));
    #50 rst_n = 1'b1;

    // Run A: full power-up; reinit pulsed in WAIT_TRFC must be ignored.
    foreach (tbl[i]) begin
      while (cyc < tbl[i].cyc) @(negedge clk);
      act = tbl[i].var_dut ? v_vec : d_vec;
      check(tbl[i].name, 32'(act),
            32'({1'b1, tbl[i].cmd, 2'b00, tbl[i].addr, tbl[i].flag}));
      if (tbl[i].pulse) begin
        #1 reinit_req = 1'b1;
        @(posedge clk);
        #1 reinit_req = 1'b0;
      end
    end

    // Reinit 10 cycles after flag: PRECHARGE next cycle, flag back 60 later.
    while (cyc < 20069) @(negedge clk);
    #1 reinit_req = 1'b1;
    model_pre = 20070;
    @(posedge clk);
    #1 reinit_req = 1'b0;
    @(negedge clk);
    check("reinit_pre", 32'(d_vec), 32'({1'b1, PRE, 2'b00, 13'h400, 1'b0}));
    n = 0;
    while (!d_flag && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reinit_flag_latency", 32'(cyc - 20070), 32'd60);

    // Run B: fresh reset, then reset again mid-refresh at cycle 20030.
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_pre = 20000;
    #1 check("rst_async_a", 32'(d_vec), 32'(RST_VEC));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    while (cyc < 20030) @(negedge clk);
    check("b_c20030_aref", 32'(d_vec), 32'({1'b1, AREF, 2'b00, 13'h000, 1'b0}));
    #2 rst_n = 1'b0;
    #1 check("rst_async_mid_d", 32'(d_vec), 32'(RST_VEC));
    check("rst_async_mid_v", 32'(v_vec), 32'(RST_VEC));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    while (cyc < 19999) @(negedge clk);
    check("b_pwr_last", 32'(d_vec), 32'({1'b1, NOP, 2'b00, 13'h000, 1'b0}));
    @(negedge clk);
    check("b_pre_20000", 32'(d_vec), 32'({1'b1, PRE, 2'b00, 13'h400, 1'b0}));
    repeat (3) @(negedge clk);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
